// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data access unit.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

    // MEM-stage memory operation encoding (4 bits wide, carried on mem_op)
    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_LWL = 4'd6,
        OP_LWR = 4'd7,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10,
        OP_SWL = 4'd11,
        OP_SWR = 4'd12
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte-enable patterns (bit i enables byte lane i, little-endian)
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LWR);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SWR);
    endfunction

    function automatic logic is_unaligned_op(input logic [3:0] op);
        return (op == OP_LWL) || (op == OP_LWR) || (op == OP_SWL) || (op == OP_SWR);
    endfunction

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0.
    // LWL/LWR/SWL/SWR are by construction never misaligned.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic m;
        m = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: m = off[0];
            OP_LW, OP_SW:         m = (off != 2'b00);
            default:              m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Store lane steering / byte enables and load extraction / LWL-LWR merge.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; outputs follow inputs.
// Ports: op/off select the operation and byte offset; wdata is the store
// source, rt_old the register merged by LWL/LWR, mem_rdata the bus word.
// wen/wdata_lane drive the bus for stores, load_data is the formatted load.
module mem_lane_fmt
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rt_old,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  wen,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (off)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        wen        = BE_NONE;
        wdata_lane = wdata;
        load_data  = mem_rdata;
        case (op)
            OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: load_data = {24'h0, byte_sel};
            OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU: load_data = {16'h0, half_sel};
            OP_LW:  load_data = mem_rdata;
            OP_LWL: begin
                case (off)
                    2'd0:    load_data = {mem_rdata[7:0],  rt_old[23:0]};
                    2'd1:    load_data = {mem_rdata[15:0], rt_old[15:0]};
                    2'd2:    load_data = {mem_rdata[23:0], rt_old[7:0]};
                    default: load_data = mem_rdata;
                endcase
            end
            OP_LWR: begin
                case (off)
                    2'd0:    load_data = mem_rdata;
                    2'd1:    load_data = {rt_old[31:24], mem_rdata[31:8]};
                    2'd2:    load_data = {rt_old[31:16], mem_rdata[31:16]};
                    default: load_data = {rt_old[31:8],  mem_rdata[31:24]};
                endcase
            end
            OP_SB: begin
                wen        = BE_B0 << off;
                wdata_lane = {4{wdata[7:0]}};
            end
            OP_SH: begin
                wen        = off[1] ? BE_HI : BE_LO;
                wdata_lane = {2{wdata[15:0]}};
            end
            OP_SW: begin
                wen        = BE_ALL;
                wdata_lane = wdata;
            end
            // SWL writes the top (off+1) bytes of rt into the low lanes
            OP_SWL: begin
                wen        = BE_ALL >> (~off);
                wdata_lane = wdata >> {~off, 3'b000};
            end
            // SWR writes the low (4-off) bytes of rt into the high lanes
            OP_SWR: begin
                wen        = BE_ALL << off;
                wdata_lane = wdata << {off, 3'b000};
            end
            default: begin
                wen        = BE_NONE;
                wdata_lane = wdata;
                load_data  = mem_rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data access: decode, alignment check, ready/ack bus transaction, load formatting.
// Latency: 3 cycles minimum (issue, ack, done); misaligned/NOP ops resolve in the same cycle.
// Backpressure: stall_req holds IF..MEM until the bus completes; hold=1 freezes the DONE result.
// Ports: clk/rst (sync, active-high); mem_op/addr/wdata/rt_old from MEM; flush/hold from
// pipeline control; stall_req, rdata_out/rdata_valid, exc_* to the pipeline; dbus_* to memory.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int UNALIGNED_EN = 1,
    parameter int MAX_WAIT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       rt_old,
    input  logic              flush,
    input  logic              hold,
    output logic              stall_req,
    output logic [31:0]       rdata_out,
    output logic              rdata_valid,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              exc_buserr,
    output logic              dbus_en,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_wen,
    output logic [31:0]       dbus_wdata,
    input  logic [31:0]       dbus_rdata,
    input  logic              dbus_ack,
    input  logic              dbus_err
);

    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int TO_LIMIT = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TO_LIMIT);

    state_e            state_q, state_d;
    logic [3:0]        op_q;
    logic [1:0]        off_q;
    logic              err_q;
    logic              kill_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic [3:0]        op_eff;
    logic              op_ld, op_st, op_misal;
    logic              issue, timeout, bus_done, bus_fail;
    logic [3:0]        fmt_op;
    logic [1:0]        fmt_off;
    logic [3:0]        lane_wen;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;

    // Without unaligned support the partial-word ops degrade to NOP
    assign op_eff   = ((UNALIGNED_EN == 0) && is_unaligned_op(mem_op)) ? OP_NOP : mem_op;
    assign op_ld    = is_load(op_eff);
    assign op_st    = is_store(op_eff);
    assign op_misal = is_misaligned(op_eff, addr[1:0]);

    assign issue    = (state_q == ST_IDLE) && (op_ld || op_st) && !op_misal && !flush;
    assign timeout  = (MAX_WAIT != 0) && (wait_cnt == TO_CNT);
    assign bus_done = (state_q == ST_WAIT) && (dbus_ack || dbus_err || timeout);
    // ack beats a simultaneous timeout; an explicit err always fails
    assign bus_fail = dbus_err || (timeout && !dbus_ack);

    // The formatter sees the live op while issuing and the captured op
    // while waiting, so the load merge uses the offset of the issued access.
    assign fmt_op  = (state_q == ST_IDLE) ? op_eff : op_q;
    assign fmt_off = (state_q == ST_IDLE) ? addr[1:0] : off_q;

    mem_lane_fmt u_lane_fmt (
        .op         (fmt_op),
        .off        (fmt_off),
        .wdata      (wdata),
        .rt_old     (rt_old),
        .mem_rdata  (dbus_rdata),
        .wen        (lane_wen),
        .wdata_lane (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_req   = 1'b0;
        exc_adel    = 1'b0;
        exc_ades    = 1'b0;
        exc_buserr  = 1'b0;
        rdata_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && (op_ld || op_st)) begin
                    if (op_misal) begin
                        exc_adel = op_ld;
                        exc_ades = op_st;
                    end else begin
                        stall_req = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // An in-flight access is never abandoned; a flush only
                // suppresses its result once the bus completes.
                stall_req = 1'b1;
                if (bus_done) begin
                    state_d = (kill_q || flush) ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rdata_valid = is_load(op_q) && !err_q;
                    exc_buserr  = err_q;
                    if (!hold) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_en    <= 1'b0;
            dbus_addr  <= '0;
            dbus_wen   <= BE_NONE;
            dbus_wdata <= 32'h0;
            rdata_out  <= 32'h0;
            op_q       <= OP_NOP;
            off_q      <= 2'b00;
            err_q      <= 1'b0;
            kill_q     <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    kill_q   <= 1'b0;
                    if (issue) begin
                        dbus_en    <= 1'b1;
                        dbus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        dbus_wen   <= lane_wen;
                        dbus_wdata <= lane_wdata;
                        op_q       <= op_eff;
                        off_q      <= addr[1:0];
                        err_q      <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (bus_done) begin
                        dbus_en  <= 1'b0;
                        dbus_wen <= BE_NONE;
                        wait_cnt <= '0;
                        err_q    <= bus_fail;
                        if (is_load(op_q) && !bus_fail && !kill_q && !flush) begin
                            rdata_out <= load_data;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a scripted bus responder.
// Latency: n/a (testbench).
// Backpressure: bench drives hold/flush directly.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt_old;
    logic        flush;
    logic        hold;
    logic        stall_req;
    logic [31:0] rdata_out;
    logic        rdata_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_buserr;
    logic        dbus_en;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wen;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        dbus_err;

    int n_cmp = 0;
    int n_err = 0;

    // Observations collected by run_op
    logic [3:0]  r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdat;
    logic [31:0] r_rdat;
    int          r_stalls;
    int          r_wcnt;
    int          r_vld_n;
    logic        r_berr;
    logic        r_adel;
    logic        r_ades;
    logic        r_bound_ok;

    mem_access_unit #(
        .ADDR_W       (32),
        .UNALIGNED_EN (1),
        .MAX_WAIT     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_op      (mem_op),
        .addr        (addr),
        .wdata       (wdata),
        .rt_old      (rt_old),
        .flush       (flush),
        .hold        (hold),
        .stall_req   (stall_req),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .exc_adel    (exc_adel),
        .exc_ades    (exc_ades),
        .exc_buserr  (exc_buserr),
        .dbus_en     (dbus_en),
        .dbus_addr   (dbus_addr),
        .dbus_wen    (dbus_wen),
        .dbus_wdata  (dbus_wdata),
        .dbus_rdata  (dbus_rdata),
        .dbus_ack    (dbus_ack),
        .dbus_err    (dbus_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Presents one op at a negedge and plays the bus slave: completes on the
    // ack_at-th WAIT cycle (0 = never), optionally with err, optionally
    // flushing on the flush_at-th WAIT cycle. Returns at the first cycle with
    // neither stall nor bus activity (DONE or IDLE), sampled 1 time unit
    // after the negedge. With hold=0, one further cycle is observed for
    // rdata_valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rt, input logic [31:0] rd, input int ack_at,
                          input bit use_err, input int flush_at);
        int  n;
        bit  done;
        r_wen = 4'hx; r_addr = 32'hx; r_wdat = 32'hx; r_rdat = 32'hx;
        r_stalls = 0; r_wcnt = 0; r_vld_n = 0;
        r_berr = 1'b0; r_adel = 1'b0; r_ades = 1'b0;
        @(negedge clk);
        mem_op = op; addr = a; wdata = wd; rt_old = rt;
        n = 0; done = 1'b0;
        while (!done && n < 60) begin
            #1;
            if (stall_req)   r_stalls++;
            if (exc_adel)    r_adel = 1'b1;
            if (exc_ades)    r_ades = 1'b1;
            if (exc_buserr)  r_berr = 1'b1;
            if (rdata_valid) begin
                r_vld_n++;
                r_rdat = rdata_out;
            end
            if (dbus_en) begin
                r_wcnt++;
                r_wen  = dbus_wen;
                r_addr = dbus_addr;
                r_wdat = dbus_wdata;
                if (r_wcnt == flush_at) begin
                    flush  = 1'b1;
                    mem_op = 4'd0;
                end
                if (r_wcnt == ack_at) begin
                    dbus_rdata = rd;
                    if (use_err) dbus_err = 1'b1;
                    else         dbus_ack = 1'b1;
                end
            end else if (!stall_req) begin
                done = 1'b1;
            end
            if (!done) begin
                @(negedge clk);
                dbus_ack = 1'b0;
                dbus_err = 1'b0;
                flush    = 1'b0;
                n++;
            end
        end
        r_bound_ok = (n < 60);
        mem_op = 4'd0;
        if (!hold) begin
            @(negedge clk);
            #1;
            if (rdata_valid) r_vld_n++;
            if (exc_buserr)  r_berr = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; mem_op = 4'd0; addr = 32'h0; wdata = 32'h0; rt_old = 32'h0;
        flush = 1'b0; hold = 1'b0; dbus_rdata = 32'h0; dbus_ack = 1'b0; dbus_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_dbus_en",   32'(dbus_en), 32'h0);
        check_val("rst_stall",     32'(stall_req), 32'h0);
        check_val("rst_rvalid",    32'(rdata_valid), 32'h0);
        check_val("rst_exc",       32'({exc_adel, exc_ades, exc_buserr}), 32'h0);
        check_val("rst_wen",       32'(dbus_wen), 32'h0);
        check_val("rst_addr",      dbus_addr, 32'h0);
        check_val("rst_wdata",     dbus_wdata, 32'h0);
        check_val("rst_rdata_out", rdata_out, 32'h0);
        rst = 1'b0;

        // LW, ack on the 2nd WAIT cycle
        run_op(4'd5, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 2, 0, 0);
        check_val("lw_bound",  32'(r_bound_ok), 32'h1);
        check_val("lw_addr",   r_addr, 32'h100);
        check_val("lw_wen",    32'(r_wen), 32'h0);
        check_val("lw_stalls", 32'(r_stalls), 32'd3);
        check_val("lw_rdata",  r_rdat, 32'hDEADBEEF);
        check_val("lw_vld_n",  32'(r_vld_n), 32'd1);

        // Sub-word loads with extension
        run_op(4'd1, 32'h103, 32'h0, 32'h0, 32'h80123456, 1, 0, 0);
        check_val("lb_rdata",  r_rdat, 32'hFFFFFF80);
        check_val("lb_stalls", 32'(r_stalls), 32'd2);
        run_op(4'd2, 32'h103, 32'h0, 32'h0, 32'h80123456, 1, 0, 0);
        check_val("lbu_rdata", r_rdat, 32'h00000080);
        run_op(4'd3, 32'h102, 32'h0, 32'h0, 32'h80123456, 1, 0, 0);
        check_val("lh_rdata",  r_rdat, 32'hFFFF8012);
        check_val("lh_addr",   r_addr, 32'h100);
        run_op(4'd4, 32'h102, 32'h0, 32'h0, 32'h80123456, 1, 0, 0);
        check_val("lhu_rdata", r_rdat, 32'h00008012);
        run_op(4'd1, 32'h101, 32'h0, 32'h0, 32'h80123456, 1, 0, 0);
        check_val("lb1_rdata", r_rdat, 32'h00000034);

        // Stores: lanes and enables
        run_op(4'd9, 32'h202, 32'h0000ABCD, 32'h0, 32'h0, 1, 0, 0);
        check_val("sh_wen",   32'(r_wen), 32'hC);
        check_val("sh_wdata", r_wdat, 32'hABCDABCD);
        check_val("sh_addr",  r_addr, 32'h200);
        check_val("sh_novld", 32'(r_vld_n), 32'd0);
        run_op(4'd11, 32'h201, 32'h11223344, 32'h0, 32'h0, 1, 0, 0);
        check_val("swl_wen",   32'(r_wen), 32'h3);
        check_val("swl_wdata", r_wdat, 32'h00001122);
        run_op(4'd12, 32'h203, 32'h11223344, 32'h0, 32'h0, 1, 0, 0);
        check_val("swr_wen",   32'(r_wen), 32'h8);
        check_val("swr_wdata", r_wdat, 32'h44000000);
        run_op(4'd8, 32'h201, 32'h000000A5, 32'h0, 32'h0, 1, 0, 0);
        check_val("sb_wen",   32'(r_wen), 32'h2);
        check_val("sb_wdata", r_wdat, 32'hA5A5A5A5);
        run_op(4'd10, 32'h204, 32'h12345678, 32'h0, 32'h0, 1, 0, 0);
        check_val("sw_wen",   32'(r_wen), 32'hF);
        check_val("sw_wdata", r_wdat, 32'h12345678);

        // Unaligned word merges
        run_op(4'd6, 32'h1, 32'h0, 32'hAABBCCDD, 32'h11223344, 1, 0, 0);
        check_val("lwl_rdata", r_rdat, 32'h3344CCDD);
        run_op(4'd7, 32'h2, 32'h0, 32'hAABBCCDD, 32'h11223344, 1, 0, 0);
        check_val("lwr_rdata", r_rdat, 32'hAABB1122);

        // Misaligned: exception, no bus access, no stall
        run_op(4'd5, 32'h102, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        check_val("adel_exc",   32'(r_adel), 32'h1);
        check_val("adel_bus",   32'(r_wcnt), 32'd0);
        check_val("adel_stall", 32'(r_stalls), 32'd0);
        run_op(4'd10, 32'h101, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        check_val("ades_exc",   32'(r_ades), 32'h1);
        check_val("ades_bus",   32'(r_wcnt), 32'd0);

        // No ack: timeout after 16 WAIT cycles
        run_op(4'd5, 32'h300, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        check_val("to_wcnt", 32'(r_wcnt), 32'd16);
        check_val("to_berr", 32'(r_berr), 32'h1);
        check_val("to_vld",  32'(r_vld_n), 32'd0);

        // Ack in the same cycle the timeout would fire: ack wins
        run_op(4'd5, 32'h300, 32'h0, 32'h0, 32'hCAFEF00D, 16, 0, 0);
        check_val("ackto_berr",  32'(r_berr), 32'h0);
        check_val("ackto_rdata", r_rdat, 32'hCAFEF00D);

        // Bus error response
        run_op(4'd5, 32'h300, 32'h0, 32'h0, 32'h0, 1, 1, 0);
        check_val("err_berr", 32'(r_berr), 32'h1);
        check_val("err_vld",  32'(r_vld_n), 32'd0);

        // Flush mid-WAIT, then ack: transaction completes silently
        run_op(4'd5, 32'h400, 32'h0, 32'h0, 32'h55555555, 3, 0, 1);
        check_val("flush_wcnt", 32'(r_wcnt), 32'd3);
        check_val("flush_vld",  32'(r_vld_n), 32'd0);
        check_val("flush_berr", 32'(r_berr), 32'h0);

        // hold=1 in DONE keeps the result for 3 cycles
        hold = 1'b1;
        run_op(4'd5, 32'h500, 32'h0, 32'h0, 32'h0BADF00D, 1, 0, 0);
        check_val("hold_v1", 32'(rdata_valid), 32'h1);
        @(negedge clk); #1;
        check_val("hold_v2", 32'(rdata_valid), 32'h1);
        @(negedge clk); #1;
        check_val("hold_v3", 32'(rdata_valid), 32'h1);
        check_val("hold_rdata", rdata_out, 32'h0BADF00D);
        hold = 1'b0;
        @(negedge clk); #1;
        check_val("hold_rel", 32'(rdata_valid), 32'h0);

        // Reset mid-WAIT
        @(negedge clk);
        mem_op = 4'd5; addr = 32'h600;
        @(negedge clk); #1;
        check_val("rstw_en", 32'(dbus_en), 32'h1);
        rst = 1'b1; mem_op = 4'd0;
        @(negedge clk); #1;
        check_val("rstw_en_after",    32'(dbus_en), 32'h0);
        check_val("rstw_stall_after", 32'(stall_req), 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        check_val("rstw_idle", 32'(dbus_en), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
